pipeline_fetch_unit: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline. Consumes the PCSrc/beq/bne/j redirect the ID-stage decoder produces.

---
 rtl/pipeline_fetch_unit.sv | 139 +++++++++++++
 tb/tb_pipeline_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, prefetches into a
//   DEPTH-entry queue and drives the IF/ID register feeding the decoder.
//   Bubble and flush slots carry NOP_WORD (opcode 6'b000001).
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-low
//   imem_addr      instruction memory address (= PC)
//   imem_rdata     instruction at imem_addr, same cycle
//   PCSrc          00 seq, 01 branch taken, 10 jump, 11 treated as seq
//   branch_target  branch target from ID
//   jump_index     instr[25:0] of the jump in ID
//   stall          hazard unit hold: no pop, no redirect, IF/ID frozen
//   ifid_instr     instruction to decoder
//   ifid_pc4       PC+4 of ifid_instr
//   ifid_valid     1 = real instruction, 0 = bubble
//   q_count        prefetch queue occupancy
//   perf_redirects redirect counter, saturating   (FETCH_PERF_EN only)
//   perf_bubbles   bubble-load counter, saturating (FETCH_PERF_EN only)
//
// Optional build macro: FETCH_PERF_EN adds the two performance counters.

module pipeline_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_WORD = 32'h0400_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic [1:0]               PCSrc,
  input  logic [31:0]              branch_target,
  input  logic [25:0]              jump_index,
  input  logic                     stall,
  output logic [31:0]              ifid_instr,
  output logic [31:0]              ifid_pc4,
  output logic                     ifid_valid,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]              perf_redirects,
  output logic [15:0]              perf_bubbles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc4   [DEPTH];

  logic          redirect;
  logic          pop;
  logic          push;
  logic          full;
  logic [31:0]   target;

  assign imem_addr = pc;

  always_comb begin
    redirect = !stall && (PCSrc == 2'b01 || PCSrc == 2'b10);
    target   = (PCSrc == 2'b01) ? branch_target
                                : {ifid_pc4[31:28], jump_index, 2'b00};
    full     = (q_count == CW'(DEPTH));
    pop      = !stall && !redirect && (q_count != '0);
    // A pop frees the head slot in the same edge, so a full queue can still accept.
    push     = !redirect && (!full || pop);
  end

  // Entry storage carries no reset; occupancy is tracked by q_count alone.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_instr[tail] <= imem_rdata;
      q_pc4[tail]   <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      q_count    <= '0;
      ifid_instr <= NOP_WORD;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      // The word fetched at the old PC this cycle is dropped with the queue.
      pc         <= target;
      head       <= '0;
      tail       <= '0;
      q_count    <= '0;
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      q_count <= q_count + CW'(push) - CW'(pop);
      if (!stall) begin
        if (pop) begin
          ifid_instr <= q_instr[head];
          ifid_pc4   <= q_pc4[head];
          ifid_valid <= 1'b1;
        end else begin
          // ifid_pc4 keeps its last value on a bubble; only valid slots use it.
          ifid_instr <= NOP_WORD;
          ifid_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_redirects <= 16'h0;
      perf_bubbles   <= 16'h0;
    end else begin
      if (redirect && perf_redirects != 16'hFFFF) begin
        perf_redirects <= perf_redirects + 16'd1;
      end
      if (!stall && !pop && perf_bubbles != 16'hFFFF) begin
        perf_bubbles <= perf_bubbles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
module tb_pipeline_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0400_0000;
  localparam logic [31:0] XMASK = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic        stall;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_redirects;
  logic [15:0] perf_bubbles;
`endif
  logic        xor_mode = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ (xor_mode ? XMASK : 32'h0);

  pipeline_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PCSrc(PCSrc), .branch_target(branch_target), .jump_index(jump_index),
    .stall(stall), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .q_count(q_count)
`ifdef FETCH_PERF_EN
    , .perf_redirects(perf_redirects), .perf_bubbles(perf_bubbles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic [1:0]  ps;
    logic [31:0] bt;
    logic [25:0] ji;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ea;
    int          eq;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic s, input logic [1:0] ps,
                      input logic [31:0] bt, input logic [25:0] ji,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ea, input int eq);
    vec_t v;
    v.r = r; v.s = s; v.ps = ps; v.bt = bt; v.ji = ji;
    v.ev = ev; v.ei = ei; v.ea = ea; v.eq = eq;
    vecs.push_back(v);
  endtask

  // Reference model: PC, a queue of fetched {instr, pc4}, and the IF/ID slot.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];
  int          m_red, m_bub;

  task automatic model_step(input logic r, input logic s, input logic [1:0] ps,
                            input logic [31:0] bt, input logic [25:0] ji);
    logic redir, pop, push;
    if (!r) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      mq_i.delete(); mq_p.delete();
      m_red = 0; m_bub = 0;
    end else begin
      redir = !s && (ps == 2'b01 || ps == 2'b10);
      if (redir) begin
        m_pc = (ps == 2'b01) ? bt : {m_pc4[31:28], ji, 2'b00};
        mq_i.delete(); mq_p.delete();
        m_instr = NOP; m_valid = 1'b0;
        if (m_red < 65535) m_red++;
        if (m_bub < 65535) m_bub++;
      end else begin
        pop  = !s && mq_i.size() != 0;
        push = mq_i.size() < DEPTH || pop;
        if (!s) begin
          if (pop) begin
            m_instr = mq_i.pop_front(); m_pc4 = mq_p.pop_front(); m_valid = 1'b1;
          end else begin
            m_instr = NOP; m_valid = 1'b0;
            if (m_bub < 65535) m_bub++;
          end
        end
        if (push) begin
          mq_i.push_back(m_pc ^ (xor_mode ? XMASK : 32'h0));
          mq_p.push_back(m_pc + 32'd4);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; PCSrc = 2'b00; branch_target = 32'h0; jump_index = 26'h0;

    //    r  s  ps     bt            ji      ev  ei            ea            q
    addv(0, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h0,        0);
    addv(0, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h0,        0);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h4,        1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h0,        32'h8,        1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h4,        32'hC,        1);
    addv(1, 0, 2'b01, 32'h100,      26'h0,  0,  NOP,          32'h100,      0);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h104,      1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h100,      32'h108,      1);
    addv(1, 1, 2'b00, 32'h0,        26'h0,  1,  32'h100,      32'h10C,      2);
    addv(1, 1, 2'b00, 32'h0,        26'h0,  1,  32'h100,      32'h110,      3);
    addv(1, 1, 2'b00, 32'h0,        26'h0,  1,  32'h100,      32'h114,      4);
    addv(1, 1, 2'b00, 32'h0,        26'h0,  1,  32'h100,      32'h114,      4);
    addv(1, 1, 2'b01, 32'h1000_0000, 26'h0, 1,  32'h100,      32'h114,      4);
    addv(1, 1, 2'b01, 32'h1000_0000, 26'h0, 1,  32'h100,      32'h114,      4);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h104,      32'h118,      4);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h108,      32'h11C,      4);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h10C,      32'h120,      4);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h110,      32'h124,      4);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h114,      32'h128,      4);
    addv(1, 0, 2'b01, 32'h1000_0000, 26'h0, 0,  NOP,          32'h1000_0000, 0);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h1000_0004, 1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h1000_0000, 32'h1000_0008, 1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h1000_0004, 32'h1000_000C, 1);
    addv(1, 0, 2'b10, 32'h0,        26'h40, 0,  NOP,          32'h1000_0100, 0);
    addv(1, 0, 2'b11, 32'h0,        26'h0,  0,  NOP,          32'h1000_0104, 1);
    addv(1, 0, 2'b00, 32'h0,        26'h0,  1,  32'h1000_0100, 32'h1000_0108, 1);
    addv(0, 0, 2'b00, 32'h0,        26'h0,  0,  NOP,          32'h0,        0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; stall = vecs[i].s; PCSrc = vecs[i].ps;
      branch_target = vecs[i].bt; jump_index = vecs[i].ji;
      @(posedge clk); #1;
      chk($sformatf("row%0d valid", i), 32'(ifid_valid), 32'(vecs[i].ev));
      chk($sformatf("row%0d instr", i), ifid_instr, vecs[i].ei);
      chk($sformatf("row%0d addr", i), imem_addr, vecs[i].ea);
      chk($sformatf("row%0d qcount", i), 32'(q_count), 32'(vecs[i].eq));
      if (vecs[i].ev) chk($sformatf("row%0d pc4", i), ifid_pc4, vecs[i].ei + 32'd4);
    end

    // Randomized run against the reference model, with scrambled memory contents.
    xor_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic       r, s;
      logic [1:0] ps;
      int         k;
      r = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 9) < 3);
      k = $urandom_range(0, 19);
      ps = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
      rst = r; stall = s; PCSrc = ps;
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_index = 26'($urandom);
      model_step(r, s, ps, branch_target, jump_index);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d qcount", c), 32'(q_count), 32'(mq_i.size()));
      chk($sformatf("rnd%0d valid", c), 32'(ifid_valid), 32'(m_valid));
      chk($sformatf("rnd%0d instr", c), ifid_instr, m_instr);
      chk($sformatf("rnd%0d pc4", c), ifid_pc4, m_pc4);
`ifdef FETCH_PERF_EN
      chk($sformatf("rnd%0d perf_redirects", c), 32'(perf_redirects), 32'(m_red));
      chk($sformatf("rnd%0d perf_bubbles", c), 32'(perf_bubbles), 32'(m_bub));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
